// File: rtl/conway_pkg.sv
// Shared types and helpers for the Life grid and its readout path.
package conway_pkg;

  // Readout sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } readout_state_t;

  // Flat board packing: cell (r,c) lives at bit r*width+c.
  function automatic int cell_bit(input int r, input int c, input int width);
    return r * width + c;
  endfunction

endpackage

// File: rtl/board_readout.sv
// Snapshot-and-stream readout: captures the board on start, then streams
// one row per valid/ready transfer, then pulses done for one cycle.
module board_readout
  import conway_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int IDX_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH*HEIGHT-1:0] board_state,
  input  logic                    start,
  output logic                    busy,
  output logic                    row_valid,
  input  logic                    row_ready,
  output logic [WIDTH-1:0]        row_data,
  output logic [IDX_W-1:0]        row_index,
  output logic                    row_last,
  output logic                    done
);

  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);

  readout_state_t          r_state;
  readout_state_t          w_state_next;
  logic [WIDTH*HEIGHT-1:0] r_snap;
  logic [IDX_W-1:0]        r_cnt;
  logic                    w_xfer;
  logic                    w_at_last;
  logic [WIDTH-1:0]        w_rows [HEIGHT];
  logic [WIDTH-1:0]        w_row_sel;

  // Unpack the snapshot into rows using the shared cell ordering.
  genvar gi, gc;
  generate
    for (gi = 0; gi < HEIGHT; gi++) begin : g_row
      for (gc = 0; gc < WIDTH; gc++) begin : g_col
        assign w_rows[gi][gc] = r_snap[cell_bit(gi, gc, WIDTH)];
      end
    end
  endgenerate

  assign w_xfer    = (r_state == SEND) && row_ready;
  assign w_at_last = (r_cnt == LAST_ROW);

  // Next-state decode; start only matters in IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SEND;
      SEND:    if (w_xfer && w_at_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Snapshot capture and row counter; the counter saturates at the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap <= '0;
      r_cnt  <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_snap <= board_state;
      r_cnt  <= '0;
    end else if (w_xfer && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Row mux selecting the snapshot row addressed by the counter.
  always_comb begin
    w_row_sel = '0;
    for (int h = 0; h < HEIGHT; h++) begin
      if (r_cnt == IDX_W'(h)) w_row_sel = w_rows[h];
    end
  end

  // Outputs decoded purely from registered state.
  assign busy      = (r_state != IDLE);
  assign row_valid = (r_state == SEND);
  assign row_data  = row_valid ? w_row_sel : '0;
  assign row_index = r_cnt;
  assign row_last  = row_valid && w_at_last;
  assign done      = (r_state == DONE);

endmodule
